addsub_seq16: RTL and testbench
===============================

ADDSUB_SEQ16 -- requirements
Module: addsub_seq16

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices processed (operand width W = 4*NIBBLES).
REQ-002 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  requester presents an operation.
REQ-005 SHALL have port req_ready  output  1  block can accept an operation.
REQ-006 SHALL have port req_a  input  W  operand A.
REQ-007 SHALL have port req_b  input  W  operand B.
REQ-008 SHALL have port req_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_result  output  W  result modulo 2^W.
REQ-012 SHALL have port rsp_carry  output  1  add: carry-out; sub: 1 = no borrow, 0 = borrow.
REQ-013 SHALL have port rsp_ovf  output  1  two's-complement signed overflow of the W-bit operation.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, CALC, DONE; req_ready = 1 only in IDLE.
REQ-016 In IDLE, req_valid&&req_ready at an edge SHALL latch req_a, req_b, req_sub, clear nibble index to 0, seed carry register with req_sub, and enter CALC.
REQ-017 Subtraction SHALL be computed as A + ~B + 1, the +1 supplied by the seeded carry into nibble 0.
REQ-018 Each CALC edge SHALL process exactly one nibble, LSB first: sum of A[idx], B[idx] (inverted if sub), carry register; write sum nibble to result[idx], store carry-out, increment idx.
REQ-019 After the edge processing nibble NIBBLES-1, SHALL enter DONE with rsp_carry = final carry-out and rsp_ovf = carry into bit W-1 XOR carry out of bit W-1.
REQ-020 Latency SHALL be exactly NIBBLES cycles: accept at edge E0, rsp_valid high after edge E(NIBBLES).
REQ-021 In DONE, rsp_valid = 1; rsp_result, rsp_carry, rsp_ovf SHALL hold stable until rsp_valid&&rsp_ready at an edge, which returns to IDLE.
REQ-022 No new request SHALL be accepted in the same cycle a response is consumed (req_ready rises one cycle after the handshake).
REQ-023 Input changes on req_a/req_b/req_sub after acceptance SHALL NOT affect the in-flight operation.
REQ-024 rsp_result/rsp_carry/rsp_ovf are don't-care outside DONE but SHALL NOT be X after reset.

Reset
REQ-025 rst_n low at an edge SHALL force IDLE, idx = 0, carry register = 0, result register = 0, rsp_carry = 0, rsp_ovf = 0, from any state, including mid-CALC (in-flight operation discarded, no response).
REQ-026 During and after reset: req_ready = 1, rsp_valid = 0, busy = 0.

Structure
REQ-027 A shared package addsub_seq_pkg SHALL hold the state enumeration and constant NIBBLE_W = 4.
REQ-028 The nibble arithmetic SHALL be one sub-module nibble_addc (4-bit a, b, cin -> 4-bit sum, cout, c3 carry into bit 3), purely combinational, instantiated once and reused every CALC cycle.
REQ-029 Controller state, index counter, operand/result registers SHALL reside in addsub_seq16.

Verification
REQ-030 Add 0x7FFF + 0x0001 -> rsp_result 0x8000, carry 0, ovf 1, rsp_valid exactly 4 cycles after accept.
REQ-031 Add 0xFFFF + 0x0001 -> 0x0000, carry 1, ovf 0; add 0x00FF + 0x0001 -> 0x0100, carry 0 (carry ripples across nibbles).
REQ-032 Sub 0x0003 - 0x0008 -> 0xFFFB, carry 0 (borrow), ovf 0; sub 0x8000 - 0x0001 -> 0x7FFF, carry 1, ovf 1; sub 0x0005 - 0x0005 -> 0x0000, carry 1.
REQ-033 Backpressure: hold rsp_ready low 3 cycles in DONE -> outputs stable, req_ready 0, busy 1; new req_valid ignored until one cycle after handshake.
REQ-034 Assert rst_n low during 2nd CALC cycle -> next cycle IDLE, rsp_valid 0, busy 0; following request 0x1234 + 0x1111 -> 0x2345, carry 0.
REQ-035 Change req_a/req_b during CALC -> result reflects latched operands only.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit:
// controller states and the slice width.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_addc.sv
// Combinational 4-bit adder slice with carry-in.
// Also exposes the carry into the top bit, used for signed overflow detection.
module nibble_addc
    import addsub_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o,
    output logic                c3_o
);

    logic [NIBBLE_W:0]   full_sum;
    logic [NIBBLE_W-1:0] low_sum;

    always_comb begin
        full_sum = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};
        // Sum of the low three bits: its MSB is the carry into bit 3.
        low_sum  = {1'b0, a_i[NIBBLE_W-2:0]} + {1'b0, b_i[NIBBLE_W-2:0]}
                 + {{(NIBBLE_W-1){1'b0}}, cin_i};
        sum_o    = full_sum[NIBBLE_W-1:0];
        cout_o   = full_sum[NIBBLE_W];
        c3_o     = low_sum[NIBBLE_W-1];
    end

endmodule

// File: rtl/addsub_seq16.sv
// Sequential add/subtract: one 4-bit slice per cycle, LSB first, with
// valid/ready handshakes on request and response.
module addsub_seq16
    import addsub_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
    input  logic                       req_sub,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] rsp_result,
    output logic                       rsp_carry,
    output logic                       rsp_ovf,
    output logic                       busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [W-1:0]        a_q, b_q;
    logic                sub_q;
    logic [W-1:0]        res_q, res_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] a_nib, b_raw, b_nib, sum_nib;
    logic                cout, c3;

    // Subtraction feeds the inverted B slice; the +1 comes from the seeded carry.
    always_comb begin
        a_nib = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        b_raw = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        b_nib = sub_q ? ~b_raw : b_raw;
    end

    nibble_addc u_nibble_addc (
        .a_i    (a_nib),
        .b_i    (b_nib),
        .cin_i  (carry_q),
        .sum_o  (sum_nib),
        .cout_o (cout),
        .c3_o   (c3)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        res_d     = res_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_d = CALC;
                    idx_d   = '0;
                    carry_d = req_sub;
                end
            end
            CALC: begin
                res_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = sum_nib;
                carry_d = cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    ovf_d   = c3 ^ cout;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operands are captured only at acceptance, so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            sub_q <= req_sub;
        end
    end

    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq16.sv
// Self-checking bench for addsub_seq16: directed corner cases, backpressure,
// mid-operation reset, operand changes in flight and randomized traffic.
module tb_addsub_seq16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_ovf;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_seq16 #(.NIBBLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    // Reference: plain unsigned/signed arithmetic on 16-bit values.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                  output logic [15:0] r, output logic c, output logic o);
        int sa, sb, sr;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            r  = a + b;
            c  = ((int'(a) + int'(b)) > 65535);
            sr = sa + sb;
        end
        o = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          output logic [15:0] r, output logic c, output logic o, output int lat);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req_a = a; req_b = b; req_sub = s; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = rsp_result; c = rsp_carry; o = rsp_ovf;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rsp_result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", rsp_result); end
        checks++; if (rsp_carry !== 1'b0 || rsp_ovf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", rsp_carry, rsp_ovf); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] va [6] = '{16'h7FFF, 16'hFFFF, 16'h00FF, 16'h0003, 16'h8000, 16'h0005};
        logic [15:0] vb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0008, 16'h0001, 16'h0005};
        logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] r, er;
        logic        c, o, ec, eo;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vs[i], r, c, o, lat);
            model(va[i], vb[i], vs[i], er, ec, eo);
            checks++; if (lat !== 4) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
            checks++; if (r !== er) begin failures++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, er); end
            checks++; if (c !== ec) begin failures++; $display("FAIL dir%0d_carry got=%b exp=%b", i, c, ec); end
            checks++; if (o !== eo) begin failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, o, eo); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, r, er;
        logic        s, c, o, ec, eo;
        int          lat;
        a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
        run_op(a, b, s, r, c, o, lat);
        model(a, b, s, er, ec, eo);
        req_a = 16'h1111; req_b = 16'h2222; req_sub = 1'b0; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== er || rsp_carry !== ec || rsp_ovf !== eo)
                begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", i, rsp_valid, rsp_result, rsp_carry, rsp_ovf, er, ec, eo); end
            checks++; if (req_ready !== 1'b0 || busy !== 1'b1)
                begin failures++; $display("FAIL bp_ctrl%0d got ready=%b busy=%b exp ready=0 busy=1", i, req_ready, busy); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0)
            begin failures++; $display("FAIL bp_after_hs got ready=%b busy=%b valid=%b exp 1/0/0", req_ready, busy, rsp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_accept_next got busy=%b exp=1", busy); end
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 4 || rsp_result !== 16'h3333 || rsp_carry !== 1'b0)
            begin failures++; $display("FAIL bp_next_op got lat=%0d res=%h c=%b exp lat=4 res=3333 c=0", lat, rsp_result, rsp_carry); end
        consume();
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] r;
        logic        c, o;
        int          lat;
        req_a = 16'hABCD; req_b = 16'h1357; req_sub = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL midrst_ctrl got ready=%b valid=%b busy=%b exp 1/0/0", req_ready, rsp_valid, busy); end
        checks++; if (rsp_result !== 16'h0000 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0)
            begin failures++; $display("FAIL midrst_data got %h/%b/%b exp 0000/0/0", rsp_result, rsp_carry, rsp_ovf); end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL midrst_no_rsp got valid=%b busy=%b exp 0/0", rsp_valid, busy); end
        run_op(16'h1234, 16'h1111, 1'b0, r, c, o, lat);
        checks++; if (r !== 16'h2345 || c !== 1'b0 || lat !== 4)
            begin failures++; $display("FAIL midrst_next got res=%h c=%b lat=%0d exp 2345/0/4", r, c, lat); end
        consume();
    endtask

    task automatic test_operand_change();
        logic [15:0] a, b, er;
        logic        s, ec, eo;
        int          lat;
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            model(a, b, s, er, ec, eo);
            req_a = a; req_b = b; req_sub = s; req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            lat = 0;
            while (!rsp_valid && lat < 20) begin
                req_a = 16'($urandom); req_b = 16'($urandom); req_sub = 1'($urandom);
                @(posedge clk); #1;
                lat++;
            end
            checks++; if (rsp_result !== er || rsp_carry !== ec || rsp_ovf !== eo || lat !== 4)
                begin failures++; $display("FAIL opchg%0d got %h/%b/%b lat=%0d exp %h/%b/%b lat=4", k, rsp_result, rsp_carry, rsp_ovf, lat, er, ec, eo); end
            consume();
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r, er;
        logic        s, c, o, ec, eo;
        int          lat, dly;
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
            if (k % 8 == 0) a = 16'h8000;
            if (k % 8 == 1) b = 16'hFFFF;
            run_op(a, b, s, r, c, o, lat);
            model(a, b, s, er, ec, eo);
            checks++; if (r !== er || c !== ec || o !== eo || lat !== 4)
                begin failures++; $display("FAIL rand%0d a=%h b=%h sub=%b got %h/%b/%b lat=%0d exp %h/%b/%b lat=4", k, a, b, s, r, c, o, lat, er, ec, eo); end
            dly = $urandom_range(0, 2);
            repeat (dly) @(posedge clk);
            #1;
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_operand_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
